// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Per-bit cycle counter: counts 0..CLKS_PER_BIT-1 and pulses bit_tick_o on the last cycle.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 868,
  parameter int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  output logic [CW-1:0] cnt_o,
  output logic          bit_tick_o
);

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign bit_tick_o = (cnt_q == CNT_LAST);
  assign cnt_o      = cnt_q;

  // A clear lands on the first cycle of a new state, so every bit starts at 0.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear_i || bit_tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// Pops bytes from an 8-bit FIFO and serialises each as a UART frame on tx.
// Optional parity bit is enabled by defining UART_TX_PARITY_EN.
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
`ifdef UART_TX_PARITY_EN
  ,
  parameter bit PARITY_ODD   = 1'b0
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       frame_done,
  output tx_state_t  dbg_state
);

  localparam int              CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   CNT_PRE_LAST = CW'(CLKS_PER_BIT - 2);
  localparam logic [2:0]      DATA_LAST    = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0]      STOP_LAST    = 3'(STOP_BITS - 1);

  tx_state_t     state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          rd_en_q, rd_en_d;
  logic          done_q, done_d;
  logic [CW-1:0] baud_cnt;
  logic          bit_tick;
  logic          baud_clear;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  assign baud_clear = (state_d != state_q);

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CW           (CW)
  ) u_baud (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (baud_clear),
    .cnt_o      (baud_cnt),
    .bit_tick_o (bit_tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (tx_en && !fifo_empty) begin
          state_d = FETCH;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        shift_d = fifo_data;
`ifdef UART_TX_PARITY_EN
        par_d   = (^fifo_data) ^ PARITY_ODD;
`endif
        state_d = START;
      end
      START: begin
        if (bit_tick) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = shift_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          state_d   = STOP;
          bit_cnt_d = '0;
        end
      end
`endif
      STOP: begin
        if (bit_tick) begin
          if (bit_cnt_q == STOP_LAST) begin
            state_d = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so the registered pins line up with state_q.
  always_comb begin
    tx_d    = UART_IDLE_LEVEL;
    rd_en_d = (state_d == FETCH);
    busy_d  = (state_d != IDLE);
    done_d  = (state_q == STOP) && (bit_cnt_q == STOP_LAST) && (baud_cnt == CNT_PRE_LAST);
    case (state_d)
      START:  tx_d = ~UART_IDLE_LEVEL;
      DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_d = par_d;
`endif
      default: tx_d = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= UART_IDLE_LEVEL;
      busy_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      rd_en_q   <= rd_en_d;
      done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign dbg_state  = state_q;

endmodule
